// File: rtl/datagram_link_pkg.sv
// Shared definitions for the game-core -> display datagram link (tx and rx).
package datagram_link_pkg;
  localparam int         MESSAGE_SIZE  = 16;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
  localparam logic       LINK_IDLE     = 1'b1;

  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, CHECKSUM, GAP} tx_state_t;

  // Whole bytes needed to carry a datagram of the given width.
  function automatic int pay_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/datagram_link_tx_bit_timer.sv
// Bit-period timer: bit_end marks the last clk of each serial bit time.
module link_bit_timer #(
  parameter int BIT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);
  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = !restart && (cnt == CW'(BIT_PERIOD - 1));

  // Free-running count within a bit; restart holds it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (restart || bit_end) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/datagram_link_tx.sv
// Framed serial transmitter: sync, LSB-first payload, XOR checksum, idle gap.
module datagram_link_tx
  import datagram_link_pkg::*;
#(
  parameter int         MSG_BITS   = MESSAGE_SIZE,
  parameter int         BIT_PERIOD = 4,
  parameter int         GAP_BITS   = 8,
  parameter logic [7:0] SYNC_WORD  = DEF_SYNC_WORD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MSG_BITS-1:0] datagram,
  input  logic                send_req,
  output logic                busy,
  output logic                tx_data,
  output logic                tx_frame,
  output logic                frame_done,
  output logic                overrun
);
  localparam int PAY_BITS = pay_bytes(MSG_BITS) * 8;
  localparam int MAXB     = (PAY_BITS > GAP_BITS) ? PAY_BITS : GAP_BITS;
  localparam int CW       = $clog2(MAXB + 1);

  tx_state_t           state, state_n;
  logic [CW-1:0]       bit_idx, lim;
  logic                bit_end, last_bit, frame_end, start;
  logic [PAY_BITS-1:0] sh, load_pad;
  logic [7:0]          csum;
  logic [MSG_BITS-1:0] pend_q;
  logic                pend_full;
  logic                tmr_restart;

  assign tmr_restart = (state == IDLE);

  link_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (tmr_restart),
    .bit_end (bit_end)
  );

  assign busy       = (state != IDLE);
  assign tx_frame   = (state == SYNC) || (state == PAYLOAD) || (state == CHECKSUM);
  assign frame_done = frame_end;
  // A request while busy with a datagram already waiting replaces it.
  assign overrun    = send_req && busy && pend_full;

  // Bit count of the current state.
  always_comb begin
    lim = CW'(8);
    case (state)
      PAYLOAD: lim = CW'(PAY_BITS);
      GAP:     lim = CW'(GAP_BITS);
      default: lim = CW'(8);
    endcase
  end

  assign last_bit = bit_end && ((bit_idx + CW'(1)) == lim);

  // Next state; a frame end with a fresh request or a waiting datagram chains
  // straight into the next sync, with the request taking priority.
  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE:     if (send_req) begin start = 1'b1; state_n = SYNC; end
      SYNC:     if (last_bit) state_n = PAYLOAD;
      PAYLOAD:  if (last_bit) state_n = CHECKSUM;
      CHECKSUM: if (last_bit) begin
                  if (GAP_BITS == 0) frame_end = 1'b1;
                  else               state_n   = GAP;
                end
      GAP:      if (last_bit) frame_end = 1'b1;
      default:  state_n = IDLE;
    endcase
    if (frame_end) begin
      if (send_req || pend_full) begin start = 1'b1; state_n = SYNC; end
      else                                          state_n = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Source for a new frame, zero-extended to whole bytes.
  always_comb begin
    load_pad                = '0;
    load_pad[MSG_BITS-1:0]  = send_req ? datagram : pend_q;
  end

  // Bit index within the current state; zero on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      bit_idx <= '0;
    else if (state_n != state || state == IDLE)   bit_idx <= '0;
    else if (bit_end)                             bit_idx <= bit_idx + CW'(1);
  end

  // Payload shifter and running XOR of payload bytes, built bit by bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      csum <= '0;
    end else if (start) begin
      sh   <= load_pad;
      csum <= '0;
    end else if (state == PAYLOAD && bit_end) begin
      sh                 <= sh >> 1;
      csum[bit_idx[2:0]] <= csum[bit_idx[2:0]] ^ sh[0];
    end
  end

  // Single-entry pending buffer; newest request wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      pend_full <= 1'b0;
    end else if (send_req && busy && !frame_end) begin
      pend_q    <= datagram;
      pend_full <= 1'b1;
    end else if (frame_end) begin
      pend_full <= 1'b0;
    end
  end

  // Serial line mux.
  always_comb begin
    tx_data = LINK_IDLE;
    case (state)
      SYNC:     tx_data = SYNC_WORD[bit_idx[2:0]];
      PAYLOAD:  tx_data = sh[0];
      CHECKSUM: tx_data = csum[bit_idx[2:0]];
      default:  tx_data = LINK_IDLE;
    endcase
  end
endmodule

// File: tb/tb_datagram_link_tx.sv
// Bench for datagram_link_tx: directed tables, hand sequences, random vs. queue model.
module tb_datagram_link_tx;
  localparam int BP = 2;
  localparam int GB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_req = 1'b0;
  logic [15:0] datagram = '0;
  logic        busy, tx_data, tx_frame, frame_done, overrun;

  logic        req_p = 1'b0;
  logic [11:0] dg_p = '0;
  logic        busy_p, tx_data_p, tx_frame_p, frame_done_p, overrun_p;

  always #5 clk = ~clk;

  datagram_link_tx #(.MSG_BITS(16), .BIT_PERIOD(BP), .GAP_BITS(GB)) u_dut (
    .clk(clk), .rst(rst), .datagram(datagram), .send_req(send_req),
    .busy(busy), .tx_data(tx_data), .tx_frame(tx_frame),
    .frame_done(frame_done), .overrun(overrun));

  // Narrow datagram, one clk per bit, no gap.
  datagram_link_tx #(.MSG_BITS(12), .BIT_PERIOD(1), .GAP_BITS(0)) u_pad (
    .clk(clk), .rst(rst), .datagram(dg_p), .send_req(req_p),
    .busy(busy_p), .tx_data(tx_data_p), .tx_frame(tx_frame_p),
    .frame_done(frame_done_p), .overrun(overrun_p));

  typedef struct packed { logic d; logic f; logic dn; } sym_t;
  typedef struct { logic [15:0] dg; logic [7:0] csum; } vec_t;

  int   nvec = 0, nerr = 0, ovr_cnt = 0;
  sym_t mq[$];
  logic [15:0] m_pend = '0;
  logic        m_pfull = 1'b0;
  logic        o_d, o_f, o_dn, o_b, o_ov;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole line waveform for one frame: every bit repeated BP clks, then gap.
  function automatic void push_frame(input logic [15:0] dg);
    logic [7:0] b[4];
    sym_t s;
    b[0] = 8'hA5; b[1] = dg[7:0]; b[2] = dg[15:8]; b[3] = dg[7:0] ^ dg[15:8];
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < BP; j++) begin
        s.d = b[i/8][i%8]; s.f = 1'b1; s.dn = 1'b0;
        mq.push_back(s);
      end
    for (int i = 0; i < GB*BP; i++) begin
      s.d = 1'b1; s.f = 1'b0; s.dn = 1'b0;
      mq.push_back(s);
    end
    s = mq.pop_back();
    s.dn = 1'b1;
    mq.push_back(s);
  endfunction

  // One clk: drive inputs after the edge, check against the model mid-cycle.
  task automatic tick(input logic r, input logic rq, input logic [15:0] dg);
    sym_t h;
    logic eb, eo;
    @(posedge clk); #1;
    rst = r; send_req = rq; datagram = dg;
    @(negedge clk);
    o_d = tx_data; o_f = tx_frame; o_dn = frame_done; o_b = busy; o_ov = overrun;
    if (o_ov) ovr_cnt++;
    h.d = 1'b1; h.f = 1'b0; h.dn = 1'b0;
    if (r) begin
      mq.delete(); m_pfull = 1'b0; eb = 1'b0; eo = 1'b0;
    end else begin
      eb = (mq.size() != 0);
      if (eb) h = mq[0];
      eo = rq && eb && m_pfull;
    end
    chk("tx_data", {31'd0, o_d}, {31'd0, h.d});
    chk("tx_frame", {31'd0, o_f}, {31'd0, h.f});
    chk("frame_done", {31'd0, o_dn}, {31'd0, h.dn});
    chk("busy", {31'd0, o_b}, {31'd0, eb});
    chk("overrun", {31'd0, o_ov}, {31'd0, eo});
    if (!r) begin
      if (!eb) begin
        if (rq) push_frame(dg);
      end else begin
        void'(mq.pop_front());
        if (h.dn) begin
          if (rq)           begin push_frame(dg);     m_pfull = 1'b0; end
          else if (m_pfull) begin push_frame(m_pend); m_pfull = 1'b0; end
        end else if (rq) begin
          m_pend = dg; m_pfull = 1'b1;
        end
      end
    end
  endtask

  // Sample one frame from its first bit, one sample per bit time.
  task automatic grab_frame(output logic [31:0] w);
    w = '0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      w[i] = o_d;
      for (int j = 1; j < BP; j++) tick(1'b0, 1'b0, 16'h0);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && o_b; i++) tick(1'b0, 1'b0, 16'h0);
    chk("drain_busy", {31'd0, o_b}, 32'd0);
  endtask

  task automatic ptick(input logic rq, input logic [11:0] dg);
    @(posedge clk); #1;
    req_p = rq; dg_p = dg; send_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    logic [31:0] ew, w;
    int          k;
    tbl[0] = '{16'h1234, 8'h26};
    tbl[1] = '{16'hBEEF, 8'h51};
    tbl[2] = '{16'h00FF, 8'hFF};
    tbl[3] = '{16'h0002, 8'h02};
    tbl[4] = '{16'h0000, 8'h00};
    tbl[5] = '{16'hFFFF, 8'h00};
    o_b = 1'b0;

    // Reset and idle.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0, 16'h0);
      chk("idle_data", {31'd0, o_d}, 32'd1);
      chk("idle_busy", {31'd0, o_b}, 32'd0);
    end
    chk("pad_reset_data", {31'd0, tx_data_p}, 32'd1);
    chk("pad_reset_busy", {31'd0, busy_p}, 32'd0);

    // Table of single frames with exact cycle timing.
    for (int v = 0; v < 6; v++) begin
      ew = {tbl[v].csum, tbl[v].dg[15:8], tbl[v].dg[7:0], 8'hA5};
      tick(1'b0, 1'b1, tbl[v].dg);
      for (int c = 1; c <= 69; c++) begin
        tick(1'b0, 1'b0, 16'h0);
        k = (c - 1) / BP;
        chk("tbl_data", {31'd0, o_d}, (c <= 64) ? {31'd0, ew[k]} : 32'd1);
        chk("tbl_frame", {31'd0, o_f}, (c <= 64) ? 32'd1 : 32'd0);
        chk("tbl_done", {31'd0, o_dn}, (c == 68) ? 32'd1 : 32'd0);
        chk("tbl_busy", {31'd0, o_b}, (c <= 68) ? 32'd1 : 32'd0);
      end
      tick(1'b0, 1'b0, 16'h0);
    end

    // Pending datagram chains straight after the gap.
    ovr_cnt = 0;
    tick(1'b0, 1'b1, 16'h1234);
    for (int c = 1; c <= 68; c++) tick(1'b0, (c == 20), (c == 20) ? 16'hBEEF : 16'h0);
    grab_frame(w);
    chk("pend_sync", {24'd0, w[7:0]}, 32'h A5);
    chk("pend_b0", {24'd0, w[15:8]}, 32'hEF);
    chk("pend_b1", {24'd0, w[23:16]}, 32'hBE);
    chk("pend_csum", {24'd0, w[31:24]}, 32'h51);
    wait_idle();
    chk("pend_no_ovr", ovr_cnt, 32'd0);

    // Overrun: second waiting request replaces the first.
    ovr_cnt = 0;
    tick(1'b0, 1'b1, 16'h1234);
    for (int c = 1; c <= 68; c++) begin
      tick(1'b0, (c == 10 || c == 12), (c == 10) ? 16'h0001 : 16'h0002);
      if (c == 12) chk("ovr_pulse", {31'd0, o_ov}, 32'd1);
    end
    grab_frame(w);
    chk("ovr_frame", w, 32'h02_00_02_A5);
    wait_idle();
    chk("ovr_count", ovr_cnt, 32'd1);

    // Reset mid-payload, then a clean frame.
    tick(1'b0, 1'b1, 16'h1234);
    for (int c = 1; c <= 30; c++) tick(1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    chk("rst_data", {31'd0, o_d}, 32'd1);
    chk("rst_frame", {31'd0, o_f}, 32'd0);
    chk("rst_busy", {31'd0, o_b}, 32'd0);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h00FF);
    grab_frame(w);
    chk("rst_clean_frame", w, 32'hFF_00_FF_A5);
    wait_idle();

    // Padding, one clk per bit, no gap.
    ew = {8'hB6, 8'h0A, 8'hBC, 8'hA5};
    ptick(1'b1, 12'hABC);
    for (int c = 1; c <= 33; c++) begin
      ptick(1'b0, 12'h0);
      chk("pad_data", {31'd0, tx_data_p}, (c <= 32) ? {31'd0, ew[c-1]} : 32'd1);
      chk("pad_frame", {31'd0, tx_frame_p}, (c <= 32) ? 32'd1 : 32'd0);
      chk("pad_done", {31'd0, frame_done_p}, (c == 32) ? 32'd1 : 32'd0);
      chk("pad_busy", {31'd0, busy_p}, (c <= 32) ? 32'd1 : 32'd0);
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 4000; i++) begin
      logic r, rq;
      r  = ($urandom_range(0, 2999) == 0);
      rq = !r && ($urandom_range(0, 39) == 0);
      tick(r, rq, 16'($urandom));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
